// File: rtl/ram_dp.sv
// Purpose: true dual-port synchronous RAM, two independent read/write ports on one clock.
// Latency: 1 cycle from address/write-enable to dout_a/dout_b (write-first on own port).
// Backpressure: none; both ports accept an access every cycle.
//
// Ports:
//   clk            single clock, all activity on the rising edge
//   rst_n          synchronous active-low reset; clears outputs, blocks writes, keeps memory
//   din_a/b        write data for port A/B
//   we_a/b         write enable (1 = write, 0 = read)
//   addr_a/b       word address
//   dout_a/b       registered read data
//   collision      (RAM_DP_COLLISION_EN only) registered same-address-with-write flag
//
// Optional feature macro: RAM_DP_COLLISION_EN
//   Adds the collision output and a cross-port bypass so a reader at the address being
//   written by the other port sees the new data instead of the old word.

module ram_dp #(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b
`ifdef RAM_DP_COLLISION_EN
  ,
  output logic              collision
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Shared storage; deliberately never reset or initialised.
  logic [DATA_W-1:0] ram [0:DEPTH-1];

  logic              same_addr;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              wr_b_en;

  logic [DATA_W-1:0] dout_a_d, dout_a_q;
  logic [DATA_W-1:0] dout_b_d, dout_b_q;
`ifdef RAM_DP_COLLISION_EN
  logic              collision_d, collision_q;
`endif

  assign same_addr = (addr_a == addr_b);

  // Port A owns the word when both ports write the same address.
  assign wr_b_en = we_b && !(we_a && same_addr);

  // Stored (pre-edge) words; a reader sees these unless the bypass applies.
  assign rd_a = ram[addr_a];
  assign rd_b = ram[addr_b];

  always_comb begin
    dout_a_d = we_a ? din_a : rd_a;
    dout_b_d = we_b ? din_b : rd_b;
`ifdef RAM_DP_COLLISION_EN
    collision_d = same_addr && (we_a || we_b);
    // A reader at the other port's write address takes the data being written.
    if (!we_a && we_b && same_addr) dout_a_d = din_b;
    if (!we_b && we_a && same_addr) dout_b_d = din_a;
`endif
  end

  // Memory writes are suppressed during reset; contents survive it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (we_a)    ram[addr_a] <= din_a;
      if (wr_b_en) ram[addr_b] <= din_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

`ifdef RAM_DP_COLLISION_EN
  always_ff @(posedge clk) begin
    if (!rst_n) collision_q <= 1'b0;
    else        collision_q <= collision_d;
  end

  assign collision = collision_q;
`endif

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: tb/tb_ram_dp.sv
// Purpose: self-checking bench for ram_dp (vector table + hand sequences + random traffic).
// Latency: expects dout one clock after each applied vector.
// Backpressure: not applicable; one vector per clock.

module tb_ram_dp;

  localparam int DW = 5;
  localparam int AW = 4;
`ifdef RAM_DP_COLLISION_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_a, din_b;
  logic          we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] dout_a, dout_b;
  logic          collision_w;

  always #5 clk = ~clk;

  ram_dp #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_a  (din_a),
    .we_a   (we_a),
    .addr_a (addr_a),
    .din_b  (din_b),
    .we_b   (we_b),
    .addr_b (addr_b),
    .dout_a (dout_a),
    .dout_b (dout_b)
`ifdef RAM_DP_COLLISION_EN
    ,
    .collision (collision_w)
`endif
  );

`ifndef RAM_DP_COLLISION_EN
  assign collision_w = 1'b0;
`endif

  typedef struct {
    logic          rst_n;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic          chk_a;
    logic          chk_b;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          exp_col;
  } vec_t;

  typedef struct {
    logic          chk_a;
    logic          chk_b;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          exp_col;
    string         tag;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[20];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [DW-1:0] mem_m [0:15];

  function automatic vec_t mk(logic r, logic wa, int aa, int da, logic wb, int ab, int db,
                              logic ca, int ea, logic cb, int eb, logic ec);
    vec_t v;
    v.rst_n = r;  v.we_a = wa; v.addr_a = AW'(aa); v.din_a = DW'(da);
    v.we_b = wb;  v.addr_b = AW'(ab); v.din_b = DW'(db);
    v.chk_a = ca; v.exp_a = DW'(ea); v.chk_b = cb; v.exp_b = DW'(eb); v.exp_col = ec;
    return v;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, then pop and compare after the edge.
  task automatic apply(vec_t v, string tag);
    sb_t e;
    sb_t got;
    rst_n = v.rst_n; we_a = v.we_a; addr_a = v.addr_a; din_a = v.din_a;
    we_b = v.we_b; addr_b = v.addr_b; din_b = v.din_b;
    e.chk_a = v.chk_a; e.chk_b = v.chk_b; e.exp_a = v.exp_a; e.exp_b = v.exp_b;
    e.exp_col = v.exp_col; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sbq.pop_front();
      if (got.chk_a) check({got.tag, ".dout_a"}, dout_a, got.exp_a);
      if (got.chk_b) check({got.tag, ".dout_b"}, dout_b, got.exp_b);
`ifdef RAM_DP_COLLISION_EN
      check({got.tag, ".collision"}, {4'b0, collision_w}, {4'b0, got.exp_col});
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;

    //          rst wa aa da  wb ab db   ca ea  cb eb  col
    tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0,   1, 0,  1, 0,  0);
    tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0,   1, 0,  1, 0,  0);
    tbl[2]  = mk(1, 1, 0, 5,  0, 8, 0,   1, 5,  0, 0,  0);
    tbl[3]  = mk(1, 1, 1, 6,  0, 8, 0,   1, 6,  0, 0,  0);
    tbl[4]  = mk(1, 1, 9, 13, 0, 8, 0,   1, 13, 0, 0,  0);
    tbl[5]  = mk(1, 1, 15,7,  0, 8, 0,   1, 7,  0, 0,  0);
    tbl[6]  = mk(1, 0, 0, 0,  0, 8, 0,   1, 5,  0, 0,  0);
    tbl[7]  = mk(1, 0, 15,0,  0, 8, 0,   1, 7,  0, 0,  0);
    tbl[8]  = mk(1, 0, 1, 0,  1, 2, 5,   1, 6,  1, 5,  0);
    tbl[9]  = mk(1, 0, 9, 0,  1, 3, 6,   1, 13, 1, 6,  0);
    tbl[10] = mk(1, 0, 0, 0,  1, 10,13,  1, 5,  1, 13, 0);
    tbl[11] = mk(1, 0, 0, 0,  1, 14,7,   1, 5,  1, 7,  0);
    tbl[12] = mk(1, 0, 10,0,  0, 14,0,   1, 13, 1, 7,  0);
    tbl[13] = mk(1, 1, 6, 16, 1, 7, 17,  1, 16, 1, 17, 0);
    tbl[14] = mk(1, 0, 7, 0,  0, 6, 0,   1, 17, 1, 16, 0);
    tbl[15] = mk(1, 1, 4, 3,  1, 4, 9,   1, 3,  1, 9,  1);
    tbl[16] = mk(1, 0, 4, 0,  0, 4, 0,   1, 3,  1, 3,  0);
    tbl[17] = mk(1, 0, 2, 0,  1, 4, 7,   1, 5,  1, 7,  0);
    tbl[18] = mk(1, 1, 4, 3,  0, 4, 0,   1, 3,  1, BYP ? 3 : 7, 1);
    tbl[19] = mk(1, 0, 4, 0,  0, 4, 0,   1, 3,  1, 3,  0);

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Stored contents after the table.
    check("ram0",  dut.ram[0],  5'd5);
    check("ram1",  dut.ram[1],  5'd6);
    check("ram9",  dut.ram[9],  5'd13);
    check("ram15", dut.ram[15], 5'd7);
    check("ram2",  dut.ram[2],  5'd5);
    check("ram3",  dut.ram[3],  5'd6);
    check("ram10", dut.ram[10], 5'd13);
    check("ram14", dut.ram[14], 5'd7);
    check("ram6",  dut.ram[6],  5'b10000);
    check("ram7",  dut.ram[7],  5'b10001);
    check("ram4",  dut.ram[4],  5'b00011);

    // Read latency: address/data changes between edges must not reach dout.
    apply(mk(1, 0, 0, 0, 0, 9, 0, 1, 5, 1, 13, 0), "lat_setup");
    addr_a = 4'd15; din_a = 5'd31; addr_b = 4'd1;
    #3;
    check("lat_hold_a", dout_a, 5'd5);
    check("lat_hold_b", dout_b, 5'd13);
    apply(mk(1, 0, 15, 31, 0, 1, 0, 1, 7, 1, 6, 0), "lat_next");

    // Reset with write traffic: outputs clear, writes are blocked, memory survives.
    apply(mk(0, 1, 0, 31, 1, 1, 30, 1, 0, 1, 0, 0), "rst0");
    apply(mk(0, 1, 9, 31, 1, 15, 30, 1, 0, 1, 0, 0), "rst1");
    check("rst_ram0",  dut.ram[0],  5'd5);
    check("rst_ram1",  dut.ram[1],  5'd6);
    check("rst_ram9",  dut.ram[9],  5'd13);
    check("rst_ram15", dut.ram[15], 5'd7);
    apply(mk(1, 0, 0, 0, 0, 15, 0, 1, 5, 1, 7, 0), "post_rst");

    // Random traffic against a reference memory; fill every word first.
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = DW'(($urandom_range(0, 31)));
      apply(mk(1, 1, i, int'(mem_m[i]), 0, 0, 0, 1, int'(mem_m[i]), 0, 0, 0),
            $sformatf("fill%0d", i));
    end
    for (int n = 0; n < 200; n++) begin
      logic          wa, wb, ec;
      logic [AW-1:0] aa, ab;
      logic [DW-1:0] da, db, ea, eb;
      wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      aa = AW'($urandom_range(0, 3)); ab = AW'($urandom_range(0, 3));
      da = DW'($urandom_range(0, 31)); db = DW'($urandom_range(0, 31));
      if (wa)                         ea = da;
      else if (BYP && wb && aa == ab) ea = db;
      else                            ea = mem_m[aa];
      if (wb)                         eb = db;
      else if (BYP && wa && aa == ab) eb = da;
      else                            eb = mem_m[ab];
      ec = (aa == ab) && (wa || wb);
      if (wb) mem_m[ab] = db;
      if (wa) mem_m[aa] = da;
      apply(mk(1, wa, int'(aa), int'(da), wb, int'(ab), int'(db), 1, int'(ea), 1, int'(eb), ec),
            $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < 4; i++) check($sformatf("rnd_ram%0d", i), dut.ram[i], mem_m[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
